mii64_rx_admit_ctrl: RTL and testbench
======================================

# mii64_rx_admit_ctrl

Packet admission controller between the XGMII-to-MII64 receive converter and the downstream packet buffer. It gates whole packets on a software enable and a downstream almost-full flag, and checks framing and frame length. It forwards admitted packets with one cycle of latency, truncates malformed packets with an error mark, and keeps per-port packet, drop and error counters. Admit and drop decisions are only ever made at start-of-packet, so the downstream never sees a partial packet without an error marker.

## Interface
- MIN_LEN, 64: minimum legal packet length in bytes, inclusive.
- MAX_LEN, 1518: maximum legal packet length in bytes, inclusive.
- Clk  in  1  the single clock for the block.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  software port enable; sampled only on a Sof beat.
- Afull  in  1  downstream almost-full; sampled only on a Sof beat.
- Rxdv  in  1  input beat valid.
- Rxd  in  64  input data.
- RxSof  in  1  first beat of packet; qualified by Rxdv.
- RxEof  in  1  last beat of packet; qualified by Rxdv.
- RxMod  in  3  valid bytes on the Eof beat; 0 means 8 bytes.
- RxErr  in  1  upstream error; qualified by Rxdv.
- OutDv  out  1  output beat valid.
- OutD  out  64  output data.
- OutSof  out  1  output first beat.
- OutEof  out  1  output last beat.
- OutMod  out  3  output valid bytes, same encoding as RxMod.
- OutErr  out  1  packet bad; only meaningful on the OutEof beat.
- PktDrop  out  1  one-cycle pulse per packet dropped at admission.
- PktCnt  out  32  good packets forwarded; wraps at 2^32.
- DropCnt  out  32  packets dropped at admission; wraps at 2^32.
- ErrCnt  out  32  packets forwarded with OutErr set, plus orphan Eofs; wraps at 2^32.

## Operation
- Beats with Rxdv=0 are ignored in every state. RxSof, RxEof, RxMod and RxErr are meaningful only when Rxdv=1.
- The state machine has three states: IDLE, PASS and DROP.
- **IDLE**
  - Sof beat with Enable=1 and Afull=0: forward the beat and load the length register.
    - If Eof is also set on that beat (single-beat packet), finish it as an Eof beat and stay in IDLE.
    - Otherwise go to PASS.
  - Sof beat with Enable=0 or Afull=1: go to DROP, pulse PktDrop, increment DropCnt. If Eof is also set, stay in IDLE.
  - Non-Sof beat: discard it. If that beat has Eof set (orphan Eof), increment ErrCnt.
- **PASS**
  - Non-Sof beat: forward it and add its byte count to the length. Every beat counts 8 bytes except the Eof beat, which counts RxMod bytes (0 counts as 8).
  - Eof beat: OutErr = RxErr sticky-OR across the packet, OR length < MIN_LEN, OR length > MAX_LEN. The length used includes the Eof beat. Increment PktCnt if OutErr=0, otherwise ErrCnt. Go to IDLE.
  - Sof beat (missing Eof): emit the beat with OutSof=0, OutEof=1, OutErr=1, OutMod=0; increment ErrCnt. Go to DROP; the new packet is discarded, with no PktDrop pulse and no DropCnt increment.
- **DROP**
  - Discard all beats.
  - Eof beat: go to IDLE.
  - Sof beat: increment ErrCnt, then evaluate the beat exactly as a Sof in IDLE.
- Length register is 16 bits and saturates at 16'hFFFF.
- Enable or Afull changing mid-packet has no effect on the packet in flight.
- Counters wrap and are never cleared except by Reset.

## Timing
- All outputs are registered, with 1-cycle latency from the input beat to OutDv/OutD/OutSof/OutEof/OutMod/OutErr.
- PktDrop and the counter updates are asserted or take effect in that same output cycle.
- Enable and Afull are sampled in the cycle the Sof beat is present at the input.
- On reset:
  - OutDv, OutSof, OutEof, OutErr and PktDrop are 0.
  - OutD and OutMod are 0.
  - All counters are 0.
  - State is IDLE, the length register is 0 and the sticky RxErr flag is clear.
- Reset asserted mid-packet abandons the packet; no OutEof is generated for it.
- Bubbles (Rxdv=0) inside a packet are permitted and produce OutDv=0 in the corresponding output cycle.
- Back-to-back packets (Eof beat followed immediately by a Sof beat) require no gap cycle.

## Test plan
- Enable=1, Afull=0; 8-beat packet with RxMod=4 (60 bytes) → 8 output beats 1 cycle later, OutEof with OutMod=4, OutErr=1 (length < MIN_LEN), ErrCnt=1, PktCnt=0.
- 8-beat packet with RxMod=0 (64 bytes), immediately followed by a 190-beat packet with RxMod=6 (1518 bytes) → both forwarded with OutErr=0, PktCnt=2, no gap cycle on the output.
- Afull=1 on the Sof beat, then deasserted mid-packet, of a 10-beat packet → no OutDv at all, PktDrop pulses once, DropCnt=1; the next packet with Afull=0 is forwarded.
- Sof arrives at beat 5 of a packet in PASS → output beat 5 has OutEof=1, OutErr=1, OutMod=0; the remaining beats of the new packet are discarded, ErrCnt=1, DropCnt=0.
- Orphan Eof beat in IDLE → no output, ErrCnt=1. Then a single-beat Sof+Eof packet with RxMod=0 → one output beat with OutSof=OutEof=1 and OutErr=1 (8 bytes < MIN_LEN).
- Reset asserted at beat 3 of a packet in PASS → next cycle all outputs and counters are 0; the following packet is forwarded normally.

Source files
------------

// File: rtl/mii64_rx_admit_ctrl.sv
// Packet admission controller for the MII64 receive path: admits or drops whole
// packets at start-of-packet, checks framing/length, and keeps per-port counters.
module mii64_rx_admit_ctrl #(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        Afull,
   input  logic        Rxdv,
   input  logic [63:0] Rxd,
   input  logic        RxSof,
   input  logic        RxEof,
   input  logic [2:0]  RxMod,
   input  logic        RxErr,
   output logic        OutDv,
   output logic [63:0] OutD,
   output logic        OutSof,
   output logic        OutEof,
   output logic [2:0]  OutMod,
   output logic        OutErr,
   output logic        PktDrop,
   output logic [31:0] PktCnt,
   output logic [31:0] DropCnt,
   output logic [31:0] ErrCnt
);

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   localparam logic [15:0] MIN_L = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);

   state_t      state_reg, state_next;
   logic [15:0] len_reg, len_next;
   logic        sticky_reg, sticky_next;

   logic        dv_next, sof_next, eof_next, err_next, drop_next;
   logic [2:0]  mod_next;
   logic        pkt_inc, drop_inc, take_sof, finish;
   logic [1:0]  err_inc;

   logic [15:0] beat_bytes;
   logic [16:0] len_sum;
   logic [15:0] len_sat;
   logic        admit;

   function automatic logic len_bad(input logic [15:0] l);
      return (l < MIN_L) || (l > MAX_L);
   endfunction

   // Only the Eof beat carries a partial byte count; 0 encodes a full beat.
   assign beat_bytes = (RxEof && (RxMod != 3'd0)) ? {13'd0, RxMod} : 16'd8;
   assign len_sum    = {1'b0, len_reg} + {1'b0, beat_bytes};
   assign len_sat    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
   assign admit      = Enable && !Afull;

   always_comb begin
      state_next  = state_reg;
      len_next    = len_reg;
      sticky_next = sticky_reg;
      dv_next     = 1'b0;
      sof_next    = 1'b0;
      eof_next    = 1'b0;
      mod_next    = RxMod;
      err_next    = 1'b0;
      drop_next   = 1'b0;
      pkt_inc     = 1'b0;
      drop_inc    = 1'b0;
      err_inc     = 2'd0;
      take_sof    = 1'b0;
      finish      = 1'b0;

      if (Rxdv) begin
         case (state_reg)
            IDLE: begin
               if (RxSof)      take_sof = 1'b1;
               else if (RxEof) err_inc  = 2'd1;
            end
            PASS: begin
               if (RxSof) begin
                  // Missing Eof: close the current packet as bad, discard the new one.
                  dv_next    = 1'b1;
                  eof_next   = 1'b1;
                  err_next   = 1'b1;
                  mod_next   = 3'd0;
                  err_inc    = 2'd1;
                  state_next = DROP;
               end else begin
                  dv_next     = 1'b1;
                  len_next    = len_sat;
                  sticky_next = sticky_reg | RxErr;
                  if (RxEof) begin
                     eof_next   = 1'b1;
                     err_next   = sticky_reg | RxErr | len_bad(len_sat);
                     finish     = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
            DROP: begin
               if (RxSof) begin
                  err_inc  = 2'd1;
                  take_sof = 1'b1;
               end else if (RxEof) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase

         if (take_sof) begin
            if (admit) begin
               dv_next     = 1'b1;
               sof_next    = 1'b1;
               len_next    = beat_bytes;
               sticky_next = RxErr;
               if (RxEof) begin
                  eof_next   = 1'b1;
                  err_next   = RxErr | len_bad(beat_bytes);
                  finish     = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = PASS;
               end
            end else begin
               drop_next  = 1'b1;
               drop_inc   = 1'b1;
               state_next = RxEof ? IDLE : DROP;
            end
         end

         if (finish) begin
            if (err_next) err_inc = err_inc + 2'd1;
            else          pkt_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg  <= IDLE;
         len_reg    <= 16'd0;
         sticky_reg <= 1'b0;
         OutDv      <= 1'b0;
         OutD       <= 64'd0;
         OutSof     <= 1'b0;
         OutEof     <= 1'b0;
         OutMod     <= 3'd0;
         OutErr     <= 1'b0;
         PktDrop    <= 1'b0;
         PktCnt     <= 32'd0;
         DropCnt    <= 32'd0;
         ErrCnt     <= 32'd0;
      end else begin
         state_reg  <= state_next;
         len_reg    <= len_next;
         sticky_reg <= sticky_next;
         OutDv      <= dv_next;
         OutSof     <= sof_next;
         OutEof     <= eof_next;
         OutErr     <= err_next;
         PktDrop    <= drop_next;
         if (dv_next) begin
            OutD   <= Rxd;
            OutMod <= mod_next;
         end
         PktCnt  <= PktCnt + {31'd0, pkt_inc};
         DropCnt <= DropCnt + {31'd0, drop_inc};
         ErrCnt  <= ErrCnt + {30'd0, err_inc};
      end
   end

endmodule

// File: tb/tb_mii64_rx_admit_ctrl.sv
// Randomized bench for mii64_rx_admit_ctrl with a packet-level reference model
// and cycle-by-cycle comparison of outputs and counters.
module tb_mii64_rx_admit_ctrl;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Enable = 1'b0, Afull = 1'b0, Rxdv = 1'b0;
   logic [63:0] Rxd = 64'd0;
   logic        RxSof = 1'b0, RxEof = 1'b0, RxErr = 1'b0;
   logic [2:0]  RxMod = 3'd0;
   logic        OutDv, OutSof, OutEof, OutErr, PktDrop;
   logic [63:0] OutD;
   logic [2:0]  OutMod;
   logic [31:0] PktCnt, DropCnt, ErrCnt;

   mii64_rx_admit_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Afull(Afull),
      .Rxdv(Rxdv), .Rxd(Rxd), .RxSof(RxSof), .RxEof(RxEof), .RxMod(RxMod), .RxErr(RxErr),
      .OutDv(OutDv), .OutD(OutD), .OutSof(OutSof), .OutEof(OutEof), .OutMod(OutMod),
      .OutErr(OutErr), .PktDrop(PktDrop), .PktCnt(PktCnt), .DropCnt(DropCnt), .ErrCnt(ErrCnt)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   // expected outputs for the beat most recently driven
   logic        exp_dv = 1'b0, exp_sof = 1'b0, exp_eof = 1'b0, exp_err = 1'b0, exp_drop = 1'b0;
   logic        exp_rst = 1'b1;
   logic [63:0] exp_d = 64'd0;
   logic [2:0]  exp_mod = 3'd0;
   logic [31:0] exp_pkt = 0, exp_dropc = 0, exp_errc = 0;

   // packet-level view of the stream
   bit in_pkt = 0, discarding = 0, bad = 0;
   int len = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      check_val("OutDv", 64'(OutDv), 64'(exp_dv));
      check_val("PktDrop", 64'(PktDrop), 64'(exp_drop));
      check_val("PktCnt", 64'(PktCnt), 64'(exp_pkt));
      check_val("DropCnt", 64'(DropCnt), 64'(exp_dropc));
      check_val("ErrCnt", 64'(ErrCnt), 64'(exp_errc));
      if (exp_dv) begin
         check_val("OutD", OutD, exp_d);
         check_val("OutSof", 64'(OutSof), 64'(exp_sof));
         check_val("OutEof", 64'(OutEof), 64'(exp_eof));
         if (exp_eof) begin
            check_val("OutMod", 64'(OutMod), 64'(exp_mod));
            check_val("OutErr", 64'(OutErr), 64'(exp_err));
            $display("pkt out: err=%0d mod=%0d pkt_cnt=%0d err_cnt=%0d", OutErr, OutMod, PktCnt, ErrCnt);
         end
      end
      if (exp_drop) $display("pkt drop: drop_cnt=%0d", DropCnt);
      if (exp_rst) begin
         check_val("rst_OutD", OutD, 64'd0);
         check_val("rst_OutMod", 64'(OutMod), 64'd0);
         check_val("rst_OutSof", 64'(OutSof), 64'd0);
         check_val("rst_OutEof", 64'(OutEof), 64'd0);
         check_val("rst_OutErr", 64'(OutErr), 64'd0);
      end
   endtask

   function automatic int eof_bytes(input logic [2:0] m);
      return (m == 3'd0) ? 8 : int'(m);
   endfunction

   task automatic finish_pkt();
      exp_eof = 1'b1;
      exp_mod = RxMod;
      exp_err = bad || (len < MIN_LEN) || (len > MAX_LEN);
      if (exp_err) exp_errc++;
      else         exp_pkt++;
      in_pkt = 0;
   endtask

   // Reference behaviour for one input cycle.
   task automatic model();
      exp_dv = 0; exp_sof = 0; exp_eof = 0; exp_err = 0; exp_drop = 0; exp_rst = 0;
      if (Reset) begin
         exp_rst = 1; exp_pkt = 0; exp_dropc = 0; exp_errc = 0;
         in_pkt = 0; discarding = 0; bad = 0; len = 0;
         return;
      end
      if (!Rxdv) return;
      if (RxSof && in_pkt) begin
         exp_dv = 1; exp_d = Rxd; exp_eof = 1; exp_err = 1; exp_mod = 0;
         exp_errc++;
         in_pkt = 0; discarding = 1;
      end else if (RxSof) begin
         if (discarding) exp_errc++;
         if (Enable && !Afull) begin
            exp_dv = 1; exp_d = Rxd; exp_sof = 1;
            bad = RxErr;
            len = RxEof ? eof_bytes(RxMod) : 8;
            in_pkt = 1; discarding = 0;
            if (RxEof) finish_pkt();
         end else begin
            exp_drop = 1; exp_dropc++;
            discarding = !RxEof;
         end
      end else if (in_pkt) begin
         exp_dv = 1; exp_d = Rxd;
         bad = bad | RxErr;
         len += RxEof ? eof_bytes(RxMod) : 8;
         if (RxEof) finish_pkt();
      end else if (discarding) begin
         if (RxEof) discarding = 0;
      end else if (RxEof) begin
         exp_errc++;
      end
   endtask

   task automatic beat(input logic dv, input logic sof, input logic eof, input logic [2:0] mod,
                       input logic err, input logic en, input logic af, input logic rst);
      @(negedge Clk);
      compare_outputs();
      Reset = rst; Rxdv = dv; RxSof = sof; RxEof = eof; RxMod = mod; RxErr = err;
      Enable = en; Afull = af; Rxd = {$urandom, $urandom};
      model();
   endtask

   task automatic idle_beat();
      // garbage on the qualified fields must be ignored
      beat(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic send_pkt(input int beats, input logic [2:0] mod, input bit en, input bit af,
                           input int err_beat, input int bubble_pct, input bit no_eof);
      for (int b = 0; b < beats; b++) begin
         logic last;
         if (b > 0 && $urandom_range(99) < bubble_pct) idle_beat();
         last = (b == beats - 1) && !no_eof;
         beat(1'b1, b == 0, last, last ? mod : 3'($urandom), b == err_beat,
              (b == 0) ? en : 1'($urandom), (b == 0) ? af : 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      beat(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
      beat(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      // 60-byte runt, then 64 and 1518 back-to-back
      send_pkt(8, 3'd4, 1, 0, -1, 0, 0);
      send_pkt(8, 3'd0, 1, 0, -1, 0, 0);
      send_pkt(190, 3'd6, 1, 0, -1, 0, 0);
      // length just outside each bound
      send_pkt(8, 3'd7, 1, 0, -1, 0, 0);
      send_pkt(190, 3'd7, 1, 0, -1, 0, 0);
      // Afull on Sof, then a normal packet
      send_pkt(10, 3'd0, 1, 1, -1, 0, 0);
      send_pkt(9, 3'd2, 1, 0, -1, 0, 0);
      // Sof arriving as beat 5 of a packet in flight
      send_pkt(4, 3'd0, 1, 0, -1, 0, 1);
      send_pkt(8, 3'd0, 1, 0, -1, 0, 0);
      // orphan Eof, then a single-beat packet
      beat(1'b1, 0, 1, 3'd0, 0, 1, 0, 1'b0);
      send_pkt(1, 3'd0, 1, 0, -1, 0, 0);
      // upstream error mid-packet
      send_pkt(12, 3'd0, 1, 0, 5, 0, 0);
      // reset mid-packet, then a normal packet
      send_pkt(3, 3'd0, 1, 0, -1, 0, 1);
      beat(1'b0, 0, 0, 0, 0, 1, 0, 1'b1);
      send_pkt(10, 3'd1, 1, 0, -1, 0, 0);
      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         int kind = $urandom_range(99);
         int nb   = ($urandom_range(9) == 0) ? $urandom_range(185, 195) : $urandom_range(1, 12);
         if (kind < 5) beat(1'b1, 0, 1, 3'($urandom), 1'($urandom), 1, 0, 1'b0);
         else send_pkt(nb, 3'($urandom), $urandom_range(99) < 85, $urandom_range(99) < 15,
                       ($urandom_range(9) == 0) ? int'($urandom_range(nb - 1)) : -1,
                       20, $urandom_range(9) == 0);
         if ($urandom_range(3) == 0) idle_beat();
      end
      beat(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      beat(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      @(negedge Clk);
      compare_outputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
